// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit sides:
// frame state encoding, default oversampling ratio and the parity rule.
package uart_pkg;

    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uartState_e;

    // Even parity wants an even number of ones across data plus parity bit, odd wants odd.
    function automatic logic parityError(input logic [7:0] data,
                                         input logic       parityBit,
                                         input logic       oddParity);
        return (^data ^ parityBit) != oddParity;
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Received-byte hand-off between the UART receiver (master) and its consumer (slave).
interface uart_rx_core_if;

    logic [7:0] data_o;
    logic       p_DataValid_o;
    logic       p_DataAck_i;
    logic       p_ParityErr_o;
    logic       p_FrameErr_o;
    logic       p_Overrun_o;

    modport master (
        output data_o,
        output p_DataValid_o,
        output p_ParityErr_o,
        output p_FrameErr_o,
        output p_Overrun_o,
        input  p_DataAck_i
    );

    modport slave (
        input  data_o,
        input  p_DataValid_o,
        input  p_ParityErr_o,
        input  p_FrameErr_o,
        input  p_Overrun_o,
        output p_DataAck_i
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous serial line; resets to the idle-high level.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: start-bit validation, 8 data bits, optional parity,
// stop-bit check, and a single held output byte with overrun reporting.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           Rx_i,
    input  logic           p_SampleTick_i,
    input  logic           p_ParityEnable_i,
    input  logic           ParityMethod_i,
    input  logic           p_BigEnd_i,
    uart_rx_core_if.master rxIf
);

    localparam int TickWidth = $clog2(OVERSAMPLE);
    localparam logic [TickWidth-1:0] TickMid  = TickWidth'(OVERSAMPLE / 2 - 1);
    localparam logic [TickWidth-1:0] TickLast = TickWidth'(OVERSAMPLE - 1);

    uartState_e           state;
    uartState_e           stateNext;
    logic                 rxS;
    logic                 rxPrev;
    logic [TickWidth-1:0] tickCnt;
    logic [2:0]           bitCnt;
    logic [7:0]           shiftReg;
    logic                 cfgParityEn;
    logic                 cfgOdd;
    logic                 cfgBigEnd;
    logic                 parityBit;
    logic                 startFrame;
    logic                 tickClear;
    logic                 tickInc;
    logic                 sampleData;
    logic                 sampleParity;
    logic                 frameDone;
    logic [7:0]           dataReg;
    logic                 validReg;
    logic                 parErrReg;
    logic                 frameErrReg;
    logic                 overrunReg;

    sync_2ff rxSync (
        .clk (clk),
        .rst (rst),
        .d   (Rx_i),
        .q   (rxS)
    );

    // Start detection is edge based, so a line stuck low never re-arms the receiver.
    always_comb begin
        stateNext    = state;
        startFrame   = 1'b0;
        tickClear    = 1'b0;
        tickInc      = 1'b0;
        sampleData   = 1'b0;
        sampleParity = 1'b0;
        frameDone    = 1'b0;
        case (state)
            IDLE: begin
                if (rxPrev && !rxS) begin
                    stateNext  = START;
                    startFrame = 1'b1;
                    tickClear  = 1'b1;
                end
            end
            START: begin
                if (p_SampleTick_i) begin
                    if (tickCnt == TickMid) begin
                        tickClear = 1'b1;
                        stateNext = rxS ? IDLE : DATA;
                    end else begin
                        tickInc = 1'b1;
                    end
                end
            end
            DATA: begin
                if (p_SampleTick_i) begin
                    if (tickCnt == TickLast) begin
                        sampleData = 1'b1;
                        tickClear  = 1'b1;
                        if (bitCnt == 3'd7) begin
                            stateNext = cfgParityEn ? PARITY : STOP;
                        end
                    end else begin
                        tickInc = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (p_SampleTick_i) begin
                    if (tickCnt == TickLast) begin
                        sampleParity = 1'b1;
                        tickClear    = 1'b1;
                        stateNext    = STOP;
                    end else begin
                        tickInc = 1'b1;
                    end
                end
            end
            STOP: begin
                if (p_SampleTick_i) begin
                    if (tickCnt == TickLast) begin
                        frameDone = 1'b1;
                        tickClear = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        tickInc = 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Frame configuration is captured at the start edge and held for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rxPrev      <= 1'b1;
            tickCnt     <= '0;
            bitCnt      <= '0;
            shiftReg    <= '0;
            cfgParityEn <= 1'b0;
            cfgOdd      <= 1'b0;
            cfgBigEnd   <= 1'b0;
            parityBit   <= 1'b0;
        end else begin
            state  <= stateNext;
            rxPrev <= rxS;
            if (tickClear) begin
                tickCnt <= '0;
            end else if (tickInc) begin
                tickCnt <= tickCnt + 1'b1;
            end
            if (startFrame) begin
                bitCnt      <= '0;
                cfgParityEn <= p_ParityEnable_i;
                cfgOdd      <= ParityMethod_i;
                cfgBigEnd   <= p_BigEnd_i;
            end
            if (sampleData) begin
                bitCnt   <= bitCnt + 1'b1;
                shiftReg <= cfgBigEnd ? {shiftReg[6:0], rxS} : {rxS, shiftReg[7:1]};
            end
            if (sampleParity) begin
                parityBit <= rxS;
            end
        end
    end

    // A finished frame replaces the held byte only if the slot is free or being acked now.
    always_ff @(posedge clk) begin
        if (rst) begin
            dataReg     <= '0;
            validReg    <= 1'b0;
            parErrReg   <= 1'b0;
            frameErrReg <= 1'b0;
            overrunReg  <= 1'b0;
        end else begin
            overrunReg <= 1'b0;
            if (frameDone) begin
                if (!validReg || rxIf.p_DataAck_i) begin
                    dataReg     <= shiftReg;
                    validReg    <= 1'b1;
                    parErrReg   <= cfgParityEn && parityError(shiftReg, parityBit, cfgOdd);
                    frameErrReg <= !rxS;
                end else begin
                    overrunReg <= 1'b1;
                end
            end else if (validReg && rxIf.p_DataAck_i) begin
                validReg    <= 1'b0;
                parErrReg   <= 1'b0;
                frameErrReg <= 1'b0;
            end
        end
    end

    assign rxIf.data_o        = dataReg;
    assign rxIf.p_DataValid_o = validReg;
    assign rxIf.p_ParityErr_o = parErrReg;
    assign rxIf.p_FrameErr_o  = frameErrReg;
    assign rxIf.p_Overrun_o   = overrunReg;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed and randomized frames for uart_rx_core, compared against a frame-level
// model of the held byte, error flags and overrun pulse.
module tb_uart_rx_core;

    localparam int Os      = 16;
    localparam int TickDiv = 4;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic Rx_i   = 1'b1;
    logic tick   = 1'b0;
    logic parEn  = 1'b0;
    logic parOdd = 1'b0;
    logic bigEnd = 1'b0;

    int checks = 0;
    int errors = 0;

    logic       mValid = 1'b0;
    logic [7:0] mData  = 8'h00;
    logic       mPerr  = 1'b0;
    logic       mFerr  = 1'b0;

    uart_rx_core_if rxIf ();

    uart_rx_core #(.OVERSAMPLE(Os)) dut (
        .clk              (clk),
        .rst              (rst),
        .Rx_i             (Rx_i),
        .p_SampleTick_i   (tick),
        .p_ParityEnable_i (parEn),
        .ParityMethod_i   (parOdd),
        .p_BigEnd_i       (bigEnd),
        .rxIf             (rxIf)
    );

    always #5 clk = ~clk;

    // Sample tick: one clk wide every TickDiv clks, changed on the falling edge.
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(negedge clk);
            phase = (phase + 1) % TickDiv;
            tick  = (phase == 0);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic expOvr);
        checkOutput({tag, ".valid"}, 8'(rxIf.p_DataValid_o), 8'(mValid));
        checkOutput({tag, ".data"}, rxIf.data_o, mData);
        checkOutput({tag, ".perr"}, 8'(rxIf.p_ParityErr_o), 8'(mPerr));
        checkOutput({tag, ".ferr"}, 8'(rxIf.p_FrameErr_o), 8'(mFerr));
        checkOutput({tag, ".ovr"}, 8'(rxIf.p_Overrun_o), 8'(expOvr));
    endtask

    task automatic waitTick();
        do @(posedge clk); while (!tick);
        #1;
    endtask

    task automatic idleBits(input int n);
        Rx_i = 1'b1;
        repeat (n * Os) waitTick();
    endtask

    task automatic ackHeld(input string tag);
        rxIf.p_DataAck_i = 1'b1;
        @(posedge clk);
        #1;
        rxIf.p_DataAck_i = 1'b0;
        mValid = 1'b0;
        mPerr  = 1'b0;
        mFerr  = 1'b0;
        checkAll(tag, 1'b0);
    endtask

    // Send one frame; stop is sampled at the (Os/2)-th tick of the stop bit.
    task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic odd,
                                 input logic big, input logic pbit, input logic stopBit,
                                 input logic ackAtDone, input string tag);
        logic bits[$];
        logic perrE;
        logic expOvr;
        waitTick();
        parEn  = pe;
        parOdd = odd;
        bigEnd = big;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(big ? d[7-i] : d[i]);
        if (pe) bits.push_back(pbit);
        foreach (bits[i]) begin
            Rx_i = bits[i];
            repeat (Os) waitTick();
            if (i == 0) begin
                parEn  = 1'($urandom);
                parOdd = 1'($urandom);
                bigEnd = 1'($urandom);
            end
        end
        Rx_i = stopBit;
        repeat (Os / 2 - 1) waitTick();
        checkOutput({tag, ".preValid"}, 8'(rxIf.p_DataValid_o), 8'(mValid));
        repeat (TickDiv - 1) @(posedge clk);
        #1;
        rxIf.p_DataAck_i = ackAtDone;
        @(posedge clk);
        #1;
        rxIf.p_DataAck_i = 1'b0;
        perrE = pe && (((($countones(d) + int'(pbit)) % 2) != int'(odd)));
        if (!mValid || ackAtDone) begin
            mValid = 1'b1;
            mData  = d;
            mPerr  = perrE;
            mFerr  = !stopBit;
            expOvr = 1'b0;
        end else begin
            expOvr = 1'b1;
        end
        checkAll(tag, expOvr);
        @(posedge clk);
        #1;
        checkOutput({tag, ".ovrEnd"}, 8'(rxIf.p_Overrun_o), 8'h00);
        repeat (Os / 2) waitTick();
    endtask

    initial begin
        rxIf.p_DataAck_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkAll("reset", 1'b0);
        rst = 1'b0;
        idleBits(2);

        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "a5_8n1");
        idleBits(1);
        ackHeld("a5_ack");

        applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "par_ok");
        idleBits(1);
        ackHeld("par_ok_ack");
        applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "par_bad");
        idleBits(1);
        ackHeld("par_bad_ack");

        applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "stop_low");
        ackHeld("stop_low_ack");
        for (int b = 0; b < 40; b++) begin
            repeat (Os) waitTick();
            checkOutput("held_low", {rxIf.p_Overrun_o, rxIf.p_DataValid_o, 6'b0}, 8'h00);
        end
        idleBits(2);

        applyStimulus(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "ovr_first");
        idleBits(1);
        applyStimulus(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "ovr_drop");
        idleBits(1);
        applyStimulus(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "ack_on_done");
        idleBits(1);
        ackHeld("ovr_ack");

        waitTick();
        Rx_i = 1'b0;
        repeat (3) waitTick();
        Rx_i = 1'b1;
        idleBits(2);
        checkAll("glitch", 1'b0);

        applyStimulus(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "pre_rst");
        idleBits(1);
        waitTick();
        Rx_i = 1'b0;
        repeat (Os) waitTick();
        for (int b = 0; b < 4; b++) begin
            Rx_i = 1'($urandom);
            repeat (Os) waitTick();
        end
        rst  = 1'b1;
        Rx_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mValid = 1'b0;
        mData  = 8'h00;
        mPerr  = 1'b0;
        mFerr  = 1'b0;
        checkAll("rst_mid", 1'b0);
        rst = 1'b0;
        idleBits(1);
        applyStimulus(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "after_rst");
        idleBits(1);
        ackHeld("after_rst_ack");

        for (int n = 0; n < 12; n++) begin
            applyStimulus(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), ($urandom_range(3) != 0), 1'($urandom),
                          $sformatf("rand%0d", n));
            idleBits(1);
            if ($urandom_range(1) == 1) ackHeld($sformatf("rand%0d_ack", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
